// File: rtl/mipi_1lane_byte_align_if.sv
// Bundles the raw D-PHY byte input, the aligned byte stream and the header/error outputs.
// Latency: none, wiring only.
// Backpressure: none; the lane streams one byte per clk_byte and cannot be stalled.
interface mipi_1lane_byte_align_if;
  logic [7:0]  raw_byte;
  logic        raw_hs_en;
  logic [7:0]  byte_data0;
  logic        rxsync_hs0;
  logic        rxvalid_hs0;
  logic [7:0]  pkt_di;
  logic [15:0] pkt_wc;
  logic        pkt_hdr_valid;
  logic [2:0]  align_ofs;
  logic        err_sot;
  logic        err_trunc;

  // Driver side: the deserializer feeding the aligner.
  modport master (
    output raw_byte, raw_hs_en,
    input  byte_data0, rxsync_hs0, rxvalid_hs0, pkt_di, pkt_wc,
    input  pkt_hdr_valid, align_ofs, err_sot, err_trunc
  );

  // Aligner side.
  modport slave (
    input  raw_byte, raw_hs_en,
    output byte_data0, rxsync_hs0, rxvalid_hs0, pkt_di, pkt_wc,
    output pkt_hdr_valid, align_ofs, err_sot, err_trunc
  );
endinterface

// File: rtl/mipi_1lane_byte_align.sv
// Finds the SoT sync byte at any bit offset in the raw HS byte stream, re-aligns the burst and parses the CSI-2 header.
// Latency: a raw byte presented in cycle t reaches byte_data0 in cycle t+2; all outputs are registered.
// Backpressure: none; the stream cannot stall, one packet per HS burst, anything after it is dropped.
module mipi_1lane_byte_align #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hB8,
  parameter int unsigned SYNC_TIMEOUT = 32
) (
  input logic                    clk_byte,
  input logic                    rst,
  mipi_1lane_byte_align_if.slave bus
);

  localparam logic [7:0] TMO_LAST = 8'(SYNC_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, HUNT, HEADER, PAYLOAD, TRAIL} state_t;

  logic [7:0]  r0_q, r1_q;
  logic        hs_pipe_q, hs_d_q, hs_prev_q;
  state_t      state_q;
  logic [7:0]  hunt_cnt_q;
  logic [1:0]  hdr_idx_q;
  logic [7:0]  di_q, wcl_q, wch_q;
  logic [16:0] rem_q;
  logic        pend_q;
  logic [7:0]  byte_q;
  logic        sync_q, vld_q, hdr_vld_q, sot_q, trunc_q;
  logic [7:0]  pkt_di_q;
  logic [15:0] pkt_wc_q;
  logic [2:0]  ofs_q;

  logic [15:0] win;
  logic        hit;
  logic [2:0]  hit_ofs;
  logic [7:0]  aligned;
  logic        hs_rise;

  // r1 holds the older byte, so window bit 0 is the earliest received bit.
  assign win     = {r0_q, r1_q};
  assign aligned = win[ofs_q +: 8];
  assign hs_rise = hs_d_q & ~hs_prev_q;

  // Search all 8 bit offsets; scanning downwards leaves the lowest matching offset.
  always_comb begin
    hit     = 1'b0;
    hit_ofs = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (win[k +: 8] == SYNC_BYTE) begin
        hit     = 1'b1;
        hit_ofs = 3'(k);
      end
    end
  end

  // Two-byte window and HS enable delayed to line up with the older window byte.
  always_ff @(posedge clk_byte) begin
    if (rst) begin
      r0_q      <= 8'h00;
      r1_q      <= 8'h00;
      hs_pipe_q <= 1'b0;
      hs_d_q    <= 1'b0;
      hs_prev_q <= 1'b0;
    end else begin
      r0_q      <= bus.raw_byte;
      r1_q      <= r0_q;
      hs_pipe_q <= bus.raw_hs_en;
      hs_d_q    <= hs_pipe_q;
      hs_prev_q <= hs_d_q;
    end
  end

  // Burst FSM with registered outputs; header fields publish one cycle after the ECC byte.
  always_ff @(posedge clk_byte) begin
    if (rst) begin
      state_q    <= IDLE;
      hunt_cnt_q <= 8'd0;
      hdr_idx_q  <= 2'd0;
      di_q       <= 8'h00;
      wcl_q      <= 8'h00;
      wch_q      <= 8'h00;
      rem_q      <= 17'd0;
      pend_q     <= 1'b0;
      byte_q     <= 8'h00;
      sync_q     <= 1'b0;
      vld_q      <= 1'b0;
      hdr_vld_q  <= 1'b0;
      sot_q      <= 1'b0;
      trunc_q    <= 1'b0;
      pkt_di_q   <= 8'h00;
      pkt_wc_q   <= 16'h0000;
      ofs_q      <= 3'd0;
    end else begin
      byte_q    <= 8'h00;
      sync_q    <= 1'b0;
      vld_q     <= 1'b0;
      sot_q     <= 1'b0;
      trunc_q   <= 1'b0;
      pend_q    <= 1'b0;
      hdr_vld_q <= pend_q;
      if (pend_q) begin
        pkt_di_q <= di_q;
        pkt_wc_q <= {wch_q, wcl_q};
      end
      case (state_q)
        IDLE: begin
          hunt_cnt_q <= 8'd0;
          if (hs_rise) state_q <= HUNT;
        end
        HUNT: begin
          hunt_cnt_q <= hunt_cnt_q + 8'd1;
          if (!hs_d_q) begin
            state_q <= IDLE;
          end else if (hit) begin
            ofs_q     <= hit_ofs;
            sync_q    <= 1'b1;
            byte_q    <= SYNC_BYTE;
            hdr_idx_q <= 2'd0;
            state_q   <= HEADER;
          end else if (hunt_cnt_q == TMO_LAST) begin
            sot_q   <= 1'b1;
            state_q <= TRAIL;
          end
        end
        HEADER: begin
          if (!hs_d_q) begin
            trunc_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            byte_q    <= aligned;
            vld_q     <= 1'b1;
            hdr_idx_q <= hdr_idx_q + 2'd1;
            case (hdr_idx_q)
              2'd0: di_q  <= aligned;
              2'd1: wcl_q <= aligned;
              2'd2: wch_q <= aligned;
              default: begin
                pend_q <= 1'b1;
                if (di_q[5:0] < 6'h10) begin
                  state_q <= TRAIL;
                end else begin
                  rem_q   <= {1'b0, wch_q, wcl_q} + 17'd2;
                  state_q <= PAYLOAD;
                end
              end
            endcase
          end
        end
        PAYLOAD: begin
          if (!hs_d_q) begin
            trunc_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            byte_q <= aligned;
            vld_q  <= 1'b1;
            rem_q  <= rem_q - 17'd1;
            if (rem_q == 17'd1) state_q <= TRAIL;
          end
        end
        TRAIL: begin
          if (!hs_d_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.byte_data0    = byte_q;
  assign bus.rxsync_hs0    = sync_q;
  assign bus.rxvalid_hs0   = vld_q;
  assign bus.pkt_di        = pkt_di_q;
  assign bus.pkt_wc        = pkt_wc_q;
  assign bus.pkt_hdr_valid = hdr_vld_q;
  assign bus.align_ofs     = ofs_q;
  assign bus.err_sot       = sot_q;
  assign bus.err_trunc     = trunc_q;

endmodule

// File: tb/tb_mipi_1lane_byte_align.sv
// Bench for the byte aligner: bursts are built as logical byte lists, bit-shifted onto the lane, and
// the expected output per cycle is derived from burst parameters (preamble, offset, length, WC).
// Outputs are compared every cycle, two cycles after the matching raw byte.
module tb_mipi_1lane_byte_align;

  localparam logic [7:0] SYNC = 8'hB8;
  localparam int         TMO  = 32;
  localparam int         NG   = 2048;

  logic clk_byte = 1'b0;
  logic rst      = 1'b1;
  always #5 clk_byte = ~clk_byte;

  mipi_1lane_byte_align_if bus();

  mipi_1lane_byte_align #(.SYNC_BYTE(SYNC), .SYNC_TIMEOUT(TMO)) dut (
    .clk_byte (clk_byte),
    .rst      (rst),
    .bus      (bus)
  );

  // Stimulus per input cycle g; expectations per evaluation index e = g - 2.
  logic [7:0]  raw_a   [NG];
  logic        hs_a    [NG];
  logic        rst_a   [NG];
  logic [7:0]  x_byte  [NG];
  logic        x_sync  [NG];
  logic        x_vld   [NG];
  logic        x_hdr   [NG];
  logic        x_sot   [NG];
  logic        x_trunc [NG];
  logic        x_rst   [NG];
  logic [7:0]  hv_di   [NG];
  logic [15:0] hv_wc   [NG];
  logic [2:0]  hv_ofs  [NG];
  logic [7:0]  x_di    [NG];
  logic [15:0] x_wc    [NG];
  logic [2:0]  x_ofs   [NG];

  logic [7:0] fixed_pl [4] = '{8'h80, 8'h10, 8'h80, 8'h20};

  int cur;
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // One HS burst of L bytes starting at cur, followed by gap idle cycles.
  // rst_c >= 0 pulses reset so that evaluation rst_c is the first cleared output cycle.
  task automatic add_burst(input bit nosync, input int npre, input int k, input int L,
                           input logic [7:0] di, input logic [15:0] wc, input int gap,
                           input int rst_c, input bit fix_pl);
    logic [7:0]  lb [$];
    logic [7:0]  prev;
    logic [15:0] w;
    int s, u, c, n_pkt, lim;
    bit is_long;
    s       = cur;
    is_long = (di[5:0] >= 6'h10);
    lim     = (rst_c >= 0) ? rst_c : NG;
    if (nosync) begin
      for (int i = 0; i < L + gap + 1; i++) lb.push_back(8'($urandom) & 8'h55);
    end else begin
      for (int i = 0; i < npre; i++) lb.push_back(8'h00);
      lb.push_back(SYNC);
      lb.push_back(di);
      lb.push_back(wc[7:0]);
      lb.push_back(wc[15:8]);
      lb.push_back(8'($urandom));
      if (is_long) begin
        for (int i = 0; i < int'(wc); i++) lb.push_back(fix_pl ? fixed_pl[i % 4] : 8'($urandom));
        lb.push_back(8'($urandom));
        lb.push_back(8'($urandom));
      end
      while (lb.size() < L + gap + 1) lb.push_back(8'($urandom));
    end
    for (int i = 0; i < L + gap; i++) begin
      prev          = (i > 0) ? lb[i-1] : 8'h00;
      w             = {lb[i], prev};
      raw_a[s + i]  = 8'(w >> (8 - k));
      hs_a[s + i]   = (i < L);
    end
    if (rst_c >= 0) begin
      rst_a[s + rst_c + 2] = 1'b1;
      x_rst[s + rst_c]     = 1'b1;
    end
    if (nosync || npre > TMO) begin
      if (L > TMO && TMO < lim) x_sot[s + TMO] = 1'b1;
    end else begin
      u = npre;
      if (u < L && u < lim) begin
        x_sync[s + u] = 1'b1;
        x_byte[s + u] = SYNC;
        hv_ofs[s + u] = 3'(k);
        n_pkt = is_long ? 7 + int'(wc) : 5;
        for (int j = 1; j < n_pkt; j++) begin
          c = u + j;
          if (c >= lim) break;
          if (c >= L) begin
            x_trunc[s + c] = 1'b1;
            break;
          end
          x_byte[s + c] = lb[c];
          x_vld[s + c]  = 1'b1;
        end
        if (u + 4 < L && u + 5 < lim) begin
          x_hdr[s + u + 5] = 1'b1;
          hv_di[s + u + 5] = di;
          hv_wc[s + u + 5] = wc;
        end
      end
    end
    cur = s + L + gap;
  endtask

  initial begin
    logic [7:0]  di;
    logic [15:0] wc;
    logic [7:0]  c_di;
    logic [15:0] c_wc;
    logic [2:0]  c_ofs;
    int k, npre, n, L, mode, e;
    bit is_long;

    for (int i = 0; i < NG; i++) begin
      raw_a[i] = 8'h00; hs_a[i] = 1'b0; rst_a[i] = 1'b0;
      x_byte[i] = 8'h00; x_sync[i] = 1'b0; x_vld[i] = 1'b0; x_hdr[i] = 1'b0;
      x_sot[i] = 1'b0; x_trunc[i] = 1'b0; x_rst[i] = 1'b0;
      hv_di[i] = 8'h00; hv_wc[i] = 16'h0000; hv_ofs[i] = 3'd0;
    end
    for (int i = 0; i < 3; i++) rst_a[i] = 1'b1;
    cur = 5;

    // Offset 0, short FS packet.
    add_burst(0, 1, 0, 1 + 5 + 3, 8'h00, 16'h0001, 3, -1, 0);
    // Offset 5, long DT 1E, WC 4, fixed payload.
    add_burst(0, 2, 5, 2 + 11 + 3, 8'h1E, 16'd4, 3, -1, 1);
    // No sync for 40 cycles: timeout, then trail.
    add_burst(1, 0, 0, 40, 8'h00, 16'h0000, 3, -1, 0);
    // WC 100 truncated after 20 payload bytes, then a normal burst.
    add_burst(0, 1, 2, 1 + 5 + 20, 8'h2A, 16'd100, 3, -1, 0);
    add_burst(0, 2, 6, 2 + 5 + 4, 8'h41, 16'hBEEF, 3, -1, 0);
    // Long packet with WC 0.
    add_burst(0, 1, 1, 1 + 7 + 2, 8'h12, 16'd0, 3, -1, 0);
    // Back-to-back bursts, offsets 3 then 7, with extra bytes after the packet.
    add_burst(0, 1, 3, 1 + 5 + 6, 8'h02, 16'h1234, 2, -1, 0);
    add_burst(0, 3, 7, 3 + 10 + 5, 8'h24, 16'd3, 2, -1, 0);
    // Reset mid-payload, then a normal burst.
    add_burst(0, 1, 4, 1 + 5 + 6 + 2, 8'h2B, 16'd20, 4, 1 + 5 + 6, 0);
    add_burst(0, 2, 0, 2 + 5 + 2, 8'h07, 16'hA5C3, 3, -1, 0);
    // Sync found exactly on the last hunt cycle wins; one cycle later is a timeout.
    add_burst(0, 32, 2, 32 + 5 + 2, 8'h01, 16'h0055, 3, -1, 0);
    add_burst(0, 33, 1, 33 + 5 + 2, 8'h01, 16'h0055, 3, -1, 0);
    // HS ends during hunt before the timeout: no error.
    add_burst(1, 0, 0, 10, 8'h00, 16'h0000, 3, -1, 0);

    for (int r = 0; r < 10; r++) begin
      k       = $urandom_range(0, 7);
      npre    = $urandom_range(1, 3);
      di      = 8'($urandom);
      is_long = (di[5:0] >= 6'h10);
      wc      = is_long ? 16'($urandom_range(0, 12)) : 16'($urandom);
      n       = is_long ? 7 + int'(wc) : 5;
      mode    = $urandom_range(0, 2);
      if (mode == 1) L = npre + $urandom_range(1, n - 1);
      else           L = npre + n + $urandom_range(0, 4);
      add_burst(0, npre, k, L, di, wc, $urandom_range(2, 5), -1, 0);
    end

    // Held header fields and offset follow their update pulses and clear on reset.
    c_di = 8'h00; c_wc = 16'h0000; c_ofs = 3'd0;
    for (int i = 0; i < NG; i++) begin
      if (x_rst[i]) begin
        c_di = 8'h00; c_wc = 16'h0000; c_ofs = 3'd0;
      end else begin
        if (x_hdr[i]) begin c_di = hv_di[i]; c_wc = hv_wc[i]; end
        if (x_sync[i]) c_ofs = hv_ofs[i];
      end
      x_di[i] = c_di; x_wc[i] = c_wc; x_ofs[i] = c_ofs;
    end

    for (int g = 0; g < cur + 4; g++) begin
      rst           = rst_a[g];
      bus.raw_byte  = raw_a[g];
      bus.raw_hs_en = hs_a[g];
      @(posedge clk_byte);
      #1;
      if (g >= 2) begin
        e = g - 2;
        chk($sformatf("byte_data0@%0d", e),    32'(bus.byte_data0),    32'(x_byte[e]));
        chk($sformatf("rxsync_hs0@%0d", e),    32'(bus.rxsync_hs0),    32'(x_sync[e]));
        chk($sformatf("rxvalid_hs0@%0d", e),   32'(bus.rxvalid_hs0),   32'(x_vld[e]));
        chk($sformatf("pkt_hdr_valid@%0d", e), 32'(bus.pkt_hdr_valid), 32'(x_hdr[e]));
        chk($sformatf("err_sot@%0d", e),       32'(bus.err_sot),       32'(x_sot[e]));
        chk($sformatf("err_trunc@%0d", e),     32'(bus.err_trunc),     32'(x_trunc[e]));
        chk($sformatf("pkt_di@%0d", e),        32'(bus.pkt_di),        32'(x_di[e]));
        chk($sformatf("pkt_wc@%0d", e),        32'(bus.pkt_wc),        32'(x_wc[e]));
        chk($sformatf("align_ofs@%0d", e),     32'(bus.align_ofs),     32'(x_ofs[e]));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mipi_1lane_byte_align.md
Name: mipi_1lane_byte_align

Overview:
- Sits directly upstream of the MIPI 1-lane YUV422 unpacker in the clk_byte domain.
- Takes the raw, unaligned 8-bit deserializer output from the D-PHY HS receiver and finds the SoT sync byte at any bit offset.
- Re-aligns every following byte and parses the CSI-2 packet header.
- Produces the byte_data0 / rxsync_hs0 / rxvalid_hs0 stream the unpacker consumes. Also exports header fields and error flags.

Parameters:
- SYNC_BYTE, 8'hB8, SoT leader pattern searched in the bit stream.
- SYNC_TIMEOUT, 32, max clk_byte cycles in HUNT before declaring SoT failure (range 2..255).

Ports:
- clk_byte  in  1  byte clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- raw_byte  in  8  unaligned deserializer byte, bit 0 received first.
- raw_hs_en  in  1  high while the lane is in HS mode (one burst per high period).
- byte_data0  out  8  aligned byte; 8'h00 when neither rxsync_hs0 nor rxvalid_hs0 is high.
- rxsync_hs0  out  1  one-cycle pulse; byte_data0 == SYNC_BYTE in this cycle.
- rxvalid_hs0  out  1  high from DI byte through last ECC (short) or last CRC (long) byte.
- pkt_di  out  8  DI byte of the last parsed header (VC[7:6], DT[5:0]).
- pkt_wc  out  16  word count of the last header, {WC_H, WC_L}.
- pkt_hdr_valid  out  1  one-cycle pulse when pkt_di / pkt_wc update.
- align_ofs  out  3  bit offset latched at the last sync detection.
- err_sot  out  1  one-cycle pulse when HUNT times out.
- err_trunc  out  1  one-cycle pulse when HS ends mid-packet.

Behaviour:

Reset:
- All outputs are 0.
- State is IDLE; pipeline registers and counters are cleared.
- Reset asserted mid-packet takes effect at the next edge. No error pulse is generated.

Pipeline:
- r0 <= raw_byte; r1 <= r0; hs_d <= raw_hs_en delayed 2 cycles.
- window = {r0, r1}; candidate k = window[k+7:k] for k = 0..7.
- All outputs are registered. A raw byte presented in cycle t contributes to byte_data0 in cycle t+2.

FSM states: IDLE, HUNT, HEADER, PAYLOAD, TRAIL.
- IDLE: wait for hs_d rising → HUNT; clear hunt counter.
- HUNT: compare all 8 candidates against SYNC_BYTE each cycle.
  - On match, pick the lowest matching k, latch align_ofs = k, output rxsync_hs0 = 1 with byte_data0 = SYNC_BYTE → HEADER.
  - The counter increments every HUNT cycle. When it reaches SYNC_TIMEOUT with no match: pulse err_sot → TRAIL.
- HEADER: output 4 aligned bytes, window[align_ofs+7:align_ofs], with rxvalid_hs0 = 1. Bytes are DI, WC_L, WC_H, ECC; the first one is on the cycle immediately after rxsync_hs0.
  - In the cycle after ECC: pulse pkt_hdr_valid; pkt_di and pkt_wc update and hold until the next header.
  - If DI[5:0] < 6'h10 (short packet): rxvalid_hs0 drops after ECC → TRAIL.
  - Otherwise → PAYLOAD with remaining = WC + 2 (16-bit WC, 17-bit counter; no wrap).
- PAYLOAD: rxvalid_hs0 = 1; one byte per cycle; remaining decrements. The last CRC byte is emitted when remaining reaches 1 → TRAIL.
  - WC = 0: PAYLOAD lasts exactly 2 cycles (CRC only).
- TRAIL: rxvalid_hs0 = 0; bytes are ignored (one packet per HS burst). hs_d low → IDLE.
- Truncation: hs_d low while in HEADER or PAYLOAD:
  - rxvalid_hs0 = 0 and byte_data0 = 0 in that output cycle; err_trunc pulses in the same cycle → IDLE.
  - pkt_hdr_valid is not issued if truncation occurs before ECC.
- hs_d low in HUNT → IDLE with no err_sot.
- Simultaneous SYNC match and timeout in the same cycle: the match wins.
- ECC and CRC are not checked; they are passed through in the byte stream.

Test Plan:
- Offset 0, FS short packet: bytes B8, 00, 01, 00, ECC → rxsync_hs0 with B8; rxvalid 4 cycles carrying 00, 01, 00, ECC; pkt_di = 00, pkt_wc = 0001, pkt_hdr_valid pulse; align_ofs = 0.
- Stream shifted by 5 bits, long DT 0x1E, WC = 4, payload 80 10 80 20, CRC 2 bytes → align_ofs = 5; rxvalid high exactly 10 cycles; byte_data0 sequence 1E, 04, 00, ECC, 80, 10, 80, 20, CRC0, CRC1; output 2 cycles after input.
- hs_en high, no B8 in 32 cycles → err_sot single pulse on cycle 32 of HUNT; no rxsync; rxvalid stays 0; TRAIL until hs_en low.
- Long packet WC = 100, hs_en drops after 20 payload bytes → err_trunc pulse aligned with the first missing output byte; rxvalid low the same cycle; next burst aligns and parses normally.
- Long packet WC = 0 → rxvalid 6 cycles; pkt_wc = 0000.
- Back-to-back bursts with different offsets (3 then 7) → align_ofs updates per burst; extra bytes after the packet in a burst never raise rxvalid.
- rst pulsed mid-PAYLOAD → next cycle all outputs 0, no error pulse; next burst parses normally.
